vic_mem_arbiter: RTL

- Shares the single synchronous video/system RAM port between the video fetch engine and the 6502 CPU bus.
- Video gets fixed priority every cycle it requests, because its fetch timing is rigid.
- CPU accesses are buffered one deep and issued in free cycles. A bounded-wait guard steals one video cycle when the CPU has waited too long; the lost fetch is flagged to the video side.
- Sits between the video module, the CPU bus glue and the RAM.

---
 rtl/vic_mem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/vic_mem_arbiter.sv
// vic_mem_arbiter: shares one synchronous RAM port between video fetch
// and a one-deep buffered CPU request, with a bounded-wait cycle steal.
module vic_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 8,
  parameter int SCW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [SCW-1:0] steal_count
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RESP,
    ACK
  } state_t;

  localparam logic [7:0]     WAIT_LIM = 8'(MAX_WAIT);
  localparam logic [SCW-1:0] SC_MAX   = '1;

  state_t        state;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic [7:0]    wait_cnt;

  logic grant;
  logic steal;
  logic accept;

  // CPU owns the port when video is idle or the wait limit is reached
  always_comb begin
    grant  = (state == PEND) &&
             (!vid_req || (wait_cnt == WAIT_LIM));
    steal  = grant && vid_req;
    accept = cpu_req && !cpu_busy;
  end

  // RAM port mux: buffered CPU access on grant, video otherwise
  always_comb begin
    mem_addr  = grant ? buf_addr : vid_addr;
    mem_we    = grant && buf_we;
    mem_wdata = grant ? buf_wdata : '0;
  end

  assign vid_data = mem_rdata;

  // Request FSM with registered handshake, video valid and steal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      wait_cnt    <= '0;
      cpu_busy    <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vid_valid   <= 1'b0;
      steal_count <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      vid_valid <= vid_req && !grant;
      if (steal && (steal_count != SC_MAX))
        steal_count <= steal_count + 1'b1;
      unique case (state)
        IDLE: ;
        PEND: begin
          if (grant)
            state <= RESP;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        RESP: begin
          if (!buf_we)
            cpu_rdata <= mem_rdata;
          cpu_busy <= 1'b0;
          cpu_ack  <= 1'b1;
          state    <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
      // IDLE and ACK both take a new request (ACK gives back-to-back)
      if (accept) begin
        buf_we    <= cpu_we;
        buf_addr  <= cpu_addr;
        buf_wdata <= cpu_wdata;
        wait_cnt  <= '0;
        cpu_busy  <= 1'b1;
        state     <= PEND;
      end
    end
  end

endmodule
